// File: rtl/counter_event_monitor_if.sv
// counter_event_monitor_if: event inputs, host strobes and statistics/FIFO outputs of the event monitor.
interface counter_event_monitor_if #(
    parameter int N_EVT      = 3,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 24,
    parameter int DEPTH_LOG2 = 3
);
    logic [N_EVT-1:0]       evt_in;
    logic                   clear;
    logic                   pop;
    logic [N_EVT-1:0]       sticky;
    logic [N_EVT*CNT_W-1:0] evt_count;
    logic [8+TS_W-1:0]      fifo_dout;
    logic                   fifo_empty;
    logic [DEPTH_LOG2:0]    fifo_level;
    logic                   overflow;

    modport master (
        output evt_in, clear, pop,
        input  sticky, evt_count, fifo_dout, fifo_empty, fifo_level, overflow
    );
    modport slave (
        input  evt_in, clear, pop,
        output sticky, evt_count, fifo_dout, fifo_empty, fifo_level, overflow
    );
endinterface

// File: rtl/counter_event_monitor.sv
// counter_event_monitor: rising-edge event statistics with a timestamped FWFT event log.
module counter_event_monitor #(
    parameter int N_EVT      = 3,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input logic                    sys_clk,
    input logic                    sys_rst_n,
    counter_event_monitor_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DW    = 8 + TS_W;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [N_EVT-1:0]      evt_q, evt_d, sticky_q, sticky_d, rise;
    logic [CNT_W-1:0]      cnt_q [N_EVT];
    logic [CNT_W-1:0]      cnt_d [N_EVT];
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [DW-1:0]         mem_q [DEPTH];
    logic [DW-1:0]         mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  empty_q, empty_d, ovf_q, ovf_d, full, do_pop, do_push;

    always_comb begin
        rise     = bus.evt_in & ~evt_q;
        evt_d    = bus.evt_in;
        ts_d     = ts_q + TS_W'(1);
        full     = level_q == LW'(DEPTH);
        do_pop   = bus.pop & ~empty_q;
        do_push  = (|rise) & (~full | do_pop);
        sticky_d = sticky_q | rise;
        for (int i = 0; i < N_EVT; i++)
            cnt_d[i] = (rise[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        mem_d = mem_q;
        if (do_push)
            mem_d[wr_q] = {8'(rise), ts_q};
        wr_d    = wr_q + DEPTH_LOG2'(do_push);
        rd_d    = rd_q + DEPTH_LOG2'(do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        ovf_d   = ovf_q | ((|rise) & full & ~do_pop);
        // clear wins over any same-cycle rise or pop; stale memory is hidden by the empty gate
        if (bus.clear) begin
            sticky_d = '0;
            cnt_d    = '{default: '0};
            wr_d     = '0;
            rd_d     = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end
        empty_d = level_d == '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_q    <= '1;
            ts_q     <= '0;
            sticky_q <= '0;
            cnt_q    <= '{default: '0};
            mem_q    <= '{default: '0};
            rd_q     <= '0;
            wr_q     <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            evt_q    <= evt_d;
            ts_q     <= ts_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    for (genvar i = 0; i < N_EVT; i++) begin : g_cnt
        assign bus.evt_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign bus.sticky     = sticky_q;
    assign bus.fifo_dout  = empty_q ? '0 : mem_q[rd_q];
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_counter_event_monitor.sv
// tb_counter_event_monitor: table vectors plus a behavioural model and entry scoreboard for the event monitor.
module tb_counter_event_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [2:0]  m_prev;
    logic [2:0]  m_sticky;
    int          m_cnt [3];
    logic        m_ovf;
    logic [7:0]  m_ts;
    logic [15:0] sb [$];

    typedef struct {
        logic [2:0] evt;
        logic [2:0] sticky;
        int         level;
        int         cnt0;
    } vec_t;
    vec_t tbl [12];

    counter_event_monitor_if #(.N_EVT(3), .CNT_W(4), .TS_W(8), .DEPTH_LOG2(3)) bus ();

    counter_event_monitor #(.N_EVT(3), .CNT_W(4), .TS_W(8), .DEPTH_LOG2(3)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = 3'b111;
        m_sticky = '0;
        m_cnt    = '{0, 0, 0};
        m_ovf    = 1'b0;
        m_ts     = '0;
        sb.delete();
    endtask

    task automatic check_all();
        chk("sticky", 64'(bus.sticky), 64'(m_sticky));
        for (int i = 0; i < 3; i++)
            chk($sformatf("evt_count[%0d]", i), 64'(bus.evt_count[i*4 +: 4]), 64'(m_cnt[i]));
        chk("fifo_level", 64'(bus.fifo_level), 64'(sb.size()));
        chk("fifo_empty", 64'(bus.fifo_empty), 64'(sb.size() == 0));
        chk("fifo_dout", 64'(bus.fifo_dout), 64'(sb.size() != 0 ? sb[0] : 16'h0));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " sticky"}, 64'(bus.sticky), 64'(0));
        chk({tag, " evt_count"}, 64'(bus.evt_count), 64'(0));
        chk({tag, " fifo_empty"}, 64'(bus.fifo_empty), 64'(1));
        chk({tag, " fifo_level"}, 64'(bus.fifo_level), 64'(0));
        chk({tag, " fifo_dout"}, 64'(bus.fifo_dout), 64'(0));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(0));
    endtask

    // One clock: drive inputs, advance the model, then compare every output against it.
    task automatic cyc(input logic [2:0] e, input logic c, input logic p);
        logic [2:0] r;
        bus.evt_in = e;
        bus.clear  = c;
        bus.pop    = p;
        r = e & ~m_prev;
        m_prev = e;
        if (c) begin
            m_sticky = '0;
            m_cnt    = '{0, 0, 0};
            m_ovf    = 1'b0;
            sb.delete();
        end else begin
            m_sticky |= r;
            for (int i = 0; i < 3; i++)
                if (r[i] && m_cnt[i] < 15) m_cnt[i]++;
            if (p && sb.size() > 0) void'(sb.pop_front());
            if (r != 0) begin
                if (sb.size() < 8) sb.push_back({5'b0, r, m_ts});
                else m_ovf = 1'b1;
            end
        end
        m_ts++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t0;
        int guard;
        bus.evt_in = '0;
        bus.clear  = 1'b0;
        bus.pop    = 1'b0;
        tbl[0]  = '{3'b000, 3'b000, 0, 0};
        tbl[1]  = '{3'b001, 3'b001, 1, 1};
        tbl[2]  = '{3'b001, 3'b001, 1, 1};
        tbl[3]  = '{3'b001, 3'b001, 1, 1};
        tbl[4]  = '{3'b001, 3'b001, 1, 1};
        tbl[5]  = '{3'b001, 3'b001, 1, 1};
        tbl[6]  = '{3'b000, 3'b001, 1, 1};
        tbl[7]  = '{3'b001, 3'b001, 2, 2};
        tbl[8]  = '{3'b001, 3'b001, 2, 2};
        tbl[9]  = '{3'b001, 3'b001, 2, 2};
        tbl[10] = '{3'b000, 3'b001, 2, 2};
        tbl[11] = '{3'b101, 3'b101, 3, 3};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        model_reset();
        rst_n = 1'b1;

        // Edge detection and simultaneous events
        for (int k = 0; k < 12; k++) begin
            cyc(tbl[k].evt, 1'b0, 1'b0);
            chk($sformatf("tbl[%0d] sticky", k), 64'(bus.sticky), 64'(tbl[k].sticky));
            chk($sformatf("tbl[%0d] level", k), 64'(bus.fifo_level), 64'(tbl[k].level));
            chk($sformatf("tbl[%0d] cnt0", k), 64'(bus.evt_count[3:0]), 64'(tbl[k].cnt0));
        end
        chk("simul cnt2", 64'(bus.evt_count[11:8]), 64'(1));
        chk("edge head1", 64'(bus.fifo_dout), 64'h0101);
        cyc(3'b000, 1'b0, 1'b1);
        chk("edge head2", 64'(bus.fifo_dout), 64'h0107);
        cyc(3'b000, 1'b0, 1'b1);
        chk("simul head", 64'(bus.fifo_dout), 64'h050B);

        // Clear priority over a same-cycle rise
        cyc(3'b100, 1'b1, 1'b0);
        chk("clear level", 64'(bus.fifo_level), 64'(0));
        chk("clear sticky", 64'(bus.sticky), 64'(0));
        chk("clear counts", 64'(bus.evt_count), 64'(0));
        cyc(3'b100, 1'b0, 1'b0);
        chk("no refire", 64'(bus.fifo_empty), 64'(1));
        cyc(3'b000, 1'b0, 1'b0);

        // FIFO fill and overflow
        t0 = m_ts;
        for (int k = 0; k < 9; k++) begin
            cyc(3'b010, 1'b0, 1'b0);
            cyc(3'b000, 1'b0, 1'b0);
        end
        chk("full level", 64'(bus.fifo_level), 64'(8));
        chk("full overflow", 64'(bus.overflow), 64'(1));
        chk("full head", 64'(bus.fifo_dout), 64'({8'h02, t0}));
        cyc(3'b010, 1'b0, 1'b1);
        chk("push+pop full level", 64'(bus.fifo_level), 64'(8));
        chk("push+pop full head", 64'(bus.fifo_dout), 64'({8'h02, t0 + 8'd2}));
        for (int k = 0; k < 8; k++) cyc(3'b000, 1'b0, 1'b1);
        chk("drained empty", 64'(bus.fifo_empty), 64'(1));
        chk("drained dout", 64'(bus.fifo_dout), 64'(0));
        cyc(3'b000, 1'b0, 1'b1);
        chk("pop empty level", 64'(bus.fifo_level), 64'(0));
        chk("pop empty overflow", 64'(bus.overflow), 64'(1));

        // Saturation
        cyc(3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(3'b001, 1'b0, 1'b1);
            cyc(3'b000, 1'b0, 1'b1);
        end
        chk("saturated cnt0", 64'(bus.evt_count[3:0]), 64'(15));

        // Timestamp wrap across logged entries
        guard = 0;
        while (m_ts != 8'd252 && guard < 300) begin
            cyc(3'b000, 1'b0, 1'b1);
            guard++;
        end
        chk("wrap reach", 64'(m_ts), 64'(252));
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        chk("wrap head0", 64'(bus.fifo_dout), 64'h01FC);
        cyc(3'b000, 1'b0, 1'b1);
        chk("wrap head1", 64'(bus.fifo_dout), 64'h01FE);
        cyc(3'b000, 1'b0, 1'b1);
        chk("wrap head2", 64'(bus.fifo_dout), 64'h0100);

        // Asynchronous reset mid-stream
        cyc(3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(3'b010, 1'b0, 1'b0);
            cyc(3'b000, 1'b0, 1'b0);
        end
        chk("pre-reset level", 64'(bus.fifo_level), 64'(4));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        cyc(3'b111, 1'b0, 1'b0);
        chk("held high no fire", 64'(bus.fifo_level), 64'(0));
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b011, 1'b0, 1'b0);
        chk("post-reset head", 64'(bus.fifo_dout), 64'h0302);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
